encoder_8x3_priority: RTL and testbench

Registered 8-to-3 priority encoder. Samples an 8-bit request vector every clock, reports the index of the highest-numbered asserted bit, and flags whether any bit was set. Used wherever a bank of request/status lines must be reduced to one binary index, such as interrupt or arbitration front-ends, with a registered, glitch-free output.

---
 rtl/encoder_pkg.sv | 10 +
 rtl/encoder_8x3_priority_core.sv | 26 ++
 rtl/encoder_8x3_priority.sv | 52 +++++
 tb/tb_encoder_8x3_priority.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared constants for the registered 8-to-3 priority encoder.
// Width, index width and the value the index register takes in reset.
package encoder_pkg;

  localparam int ENC_WIDTH = 8;
  localparam int ENC_IDX_W = 3;

  localparam logic [ENC_IDX_W-1:0] ENC_OUT_RST = 3'b000;

endpackage : encoder_pkg

// File: rtl/encoder_8x3_priority_core.sv
// Combinational priority core: index of the highest set request bit plus an any-set flag.
// An all-zero vector yields idx = 0 and any = 0, so idx is never X or stale.
module encoder_8x3_priority_core
  import encoder_pkg::*;
#(
  parameter int WIDTH = ENC_WIDTH,
  parameter int OUT_W = ENC_IDX_W
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [OUT_W-1:0] idx_o,
  output logic             any_o
);

  // Ascending scan; the last (highest) set bit found wins.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req_i[i]) begin
        idx_o = i[OUT_W-1:0];
      end
    end
  end

  assign any_o = |req_i;

endmodule : encoder_8x3_priority_core

// File: rtl/encoder_8x3_priority.sv
// Registered 8-to-3 priority encoder: one vector sampled per clock, result one cycle later.
// Interface contract: no valid/ready handshake; in is consumed every cycle and valid qualifies out.
module encoder_8x3_priority
  import encoder_pkg::*;
#(
  parameter int WIDTH = ENC_WIDTH,
  parameter int OUT_W = ENC_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic             valid
);

  logic [OUT_W-1:0] idx;
  logic             any;

  logic [OUT_W-1:0] out_d;
  logic [OUT_W-1:0] out_q;
  logic             valid_d;
  logic             valid_q;

  encoder_8x3_priority_core #(
    .WIDTH (WIDTH),
    .OUT_W (OUT_W)
  ) u_core (
    .req_i (in),
    .idx_o (idx),
    .any_o (any)
  );

  always_comb begin
    out_d   = idx;
    valid_d = any;
  end

  // Reset wins over the sampled vector; that edge's input is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= ENC_OUT_RST;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;

endmodule : encoder_8x3_priority

// File: tb/tb_encoder_8x3_priority.sv
// Self-checking bench for encoder_8x3_priority.
// Reference index is floor(log2(v)) computed by repeated halving.
module tb_encoder_8x3_priority;

  logic       clk;
  logic       rst;
  logic [7:0] in;
  logic [2:0] out;
  logic       valid;

  int n_cmp;
  int n_fail;

  logic [3:0] exp_q[$];

  encoder_8x3_priority dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .out   (out),
    .valid (valid)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] model(input logic [7:0] v);
    int x;
    int n;
    x = v;
    n = 0;
    while (x > 1) begin
      x = x / 2;
      n++;
    end
    // {valid, out}
    return {(v != 8'd0), n[2:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [7:0] v);
    @(negedge clk);
    rst = r;
    in  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 8'hFF);
      n_cmp++;
      if ({valid, out} !== 4'b0_000) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got valid=%b out=%0d, want valid=0 out=0", c, valid, out);
      end
    end
    drive(1'b0, 8'hFF);
    n_cmp++;
    if ({valid, out} !== 4'b1_111) begin
      n_fail++;
      $display("FAIL reset_release: got valid=%b out=%0d, want valid=1 out=7", valid, out);
    end
  endtask

  task automatic test_no_request();
    drive(1'b0, 8'h00);
    n_cmp++;
    if ({valid, out} !== 4'b0_000) begin
      n_fail++;
      $display("FAIL no_request: got valid=%b out=%0d, want valid=0 out=0", valid, out);
    end
  endtask

  task automatic test_single();
    drive(1'b0, 8'b0000_0001);
    n_cmp++;
    if ({valid, out} !== 4'b1_000) begin
      n_fail++;
      $display("FAIL single_bit0: got valid=%b out=%0d, want valid=1 out=0", valid, out);
    end
    drive(1'b0, 8'b1000_0000);
    n_cmp++;
    if ({valid, out} !== 4'b1_111) begin
      n_fail++;
      $display("FAIL single_bit7: got valid=%b out=%0d, want valid=1 out=7", valid, out);
    end
  endtask

  task automatic test_priority();
    logic [7:0] vecs[4];
    logic [2:0] idxs[4];
    vecs = '{8'b0000_0011, 8'b0000_0101, 8'b0001_1000, 8'b1001_1011};
    idxs = '{3'd1, 3'd2, 3'd4, 3'd7};
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, vecs[k]);
      n_cmp++;
      if ({valid, out} !== {1'b1, idxs[k]}) begin
        n_fail++;
        $display("FAIL priority[%b]: got valid=%b out=%0d, want valid=1 out=%0d",
                 vecs[k], valid, out, idxs[k]);
      end
    end
  endtask

  // All 256 values on consecutive cycles, then a random run, scored through exp_q.
  task automatic test_back_to_back();
    logic [7:0] v;
    logic [3:0] e;
    exp_q.delete();
    for (int k = 0; k < 256 + 200; k++) begin
      v = (k < 256) ? 8'(k) : 8'($urandom_range(0, 255));
      exp_q.push_back(model(v));
      drive(1'b0, v);
      e = exp_q.pop_front();
      n_cmp++;
      if ({valid, out} !== e) begin
        n_fail++;
        $display("FAIL back_to_back[in=%b]: got valid=%b out=%0d, want valid=%b out=%0d",
                 v, valid, out, e[3], e[2:0]);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    drive(1'b0, 8'b0010_0000);
    n_cmp++;
    if ({valid, out} !== 4'b1_101) begin
      n_fail++;
      $display("FAIL mid_pre: got valid=%b out=%0d, want valid=1 out=5", valid, out);
    end
    drive(1'b1, 8'b0010_0000);
    n_cmp++;
    if ({valid, out} !== 4'b0_000) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b out=%0d, want valid=0 out=0", valid, out);
    end
    drive(1'b0, 8'b0010_0000);
    n_cmp++;
    if ({valid, out} !== 4'b1_101) begin
      n_fail++;
      $display("FAIL mid_release: got valid=%b out=%0d, want valid=1 out=5", valid, out);
    end
  endtask

  // Random vectors with random reset pulses mixed in.
  task automatic test_random_reset();
    logic [7:0] v;
    logic       r;
    logic [3:0] e;
    for (int k = 0; k < 100; k++) begin
      v = 8'($urandom_range(0, 255));
      r = ($urandom_range(0, 7) == 0);
      e = r ? 4'b0_000 : model(v);
      drive(r, v);
      n_cmp++;
      if ({valid, out} !== e) begin
        n_fail++;
        $display("FAIL random_reset[rst=%b in=%b]: got valid=%b out=%0d, want valid=%b out=%0d",
                 r, v, valid, out, e[3], e[2:0]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    in     = 8'h00;
    test_reset();
    test_no_request();
    test_single();
    test_priority();
    test_back_to_back();
    test_reset_mid_stream();
    test_random_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_encoder_8x3_priority
